// File: rtl/cpu_mem_system_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_system_if
// Bus bundle between the pipeline core (and program loader / console
// consumer) and the cpu_mem_system memory responder.
//
// Signals:
//   pc            fetch byte address            (core -> mem)
//   if_inst       fetched instruction word      (mem -> core, combinational)
//   mem_alu_out   data byte address             (core -> mem)
//   mem_reg_mem   store data                    (core -> mem)
//   mem_mem_write store strobe                  (core -> mem)
//   mem_mem_out   load data                     (mem -> core, combinational)
//   prog_we       instruction RAM write enable  (loader -> mem)
//   prog_addr     instruction RAM word index    (loader -> mem)
//   prog_data     instruction word to write     (loader -> mem)
//   con_data      console byte at FIFO head     (mem -> consumer)
//   con_valid     console FIFO non-empty        (mem -> consumer)
//   con_ready     consumer takes con_data       (consumer -> mem)
//   led           LED register                  (mem -> board)
//
// Modports: slave = memory side, master = core / environment side.
// ----------------------------------------------------------------------------
interface cpu_mem_system_if;
    logic [31:0] pc;
    logic [31:0] if_inst;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_reg_mem;
    logic        mem_mem_write;
    logic [31:0] mem_mem_out;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;
    logic [15:0] led;

    modport slave (
        input  pc,
        input  mem_alu_out,
        input  mem_reg_mem,
        input  mem_mem_write,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        input  con_ready,
        output if_inst,
        output mem_mem_out,
        output con_data,
        output con_valid,
        output led
    );

    modport master (
        output pc,
        output mem_alu_out,
        output mem_reg_mem,
        output mem_mem_write,
        output prog_we,
        output prog_addr,
        output prog_data,
        output con_ready,
        input  if_inst,
        input  mem_mem_out,
        input  con_data,
        input  con_valid,
        input  led
    );
endinterface

// File: rtl/cpu_mem_system.sv
// ----------------------------------------------------------------------------
// cpu_mem_system
// Memory-side responder for the 5-stage MIPS core: instruction RAM with a
// program-load port, data RAM, and a 16-byte I/O page holding an LED
// register, a console TX FIFO, a status register and a cycle counter.
// All reads are combinational; all writes land on the rising clock edge.
//
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-low reset
//   bus    cpu_mem_system_if.slave (fetch, data, program-load, console, led)
//
// I/O page (byte base IO_BASE, word offset = address[3:2]):
//   0 LED       read {16'b0, led}, write led <= data[15:0]
//   1 CON_TX    read 0, write pushes data[7:0]
//   2 CON_STAT  read {22'b0, drop, full, count[7:0]}, write clears drop
//   3 CYCLE     read counter, write loads counter
// ----------------------------------------------------------------------------
module cpu_mem_system #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter int          CON_DEPTH  = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic            clock,
    input  logic            reset,
    cpu_mem_system_if.slave bus
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);
    localparam int CON_AW  = $clog2(CON_DEPTH);
    localparam int CNT_W   = CON_AW + 1;

    localparam logic [1:0] OFF_LED  = 2'd0;
    localparam logic [1:0] OFF_TX   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CYC  = 2'd3;

    // ------------------------------------------------------------------
    // Instruction RAM
    // ------------------------------------------------------------------
    logic [31:0]        imem [IMEM_WORDS];
    logic               fetch_hit;
    logic [IMEM_AW-1:0] fetch_idx;
    logic               prog_hit;

    assign fetch_hit   = (bus.pc[31:IMEM_AW+2] == '0);
    assign fetch_idx   = bus.pc[IMEM_AW+1:2];
    assign bus.if_inst = fetch_hit ? imem[fetch_idx] : 32'h0;

    assign prog_hit = (bus.prog_addr[31:IMEM_AW] == '0);

    always_ff @(posedge clock) begin
        if (reset && bus.prog_we && prog_hit) begin
            imem[bus.prog_addr[IMEM_AW-1:0]] <= bus.prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Data-side address decode
    // ------------------------------------------------------------------
    logic [31:0]        addr;
    logic               dmem_hit;
    logic [DMEM_AW-1:0] dmem_idx;
    logic               io_hit;
    logic [1:0]         io_off;
    logic               wr_en;

    assign addr     = bus.mem_alu_out;
    // The RAM window must also sit below the I/O page, so a large RAM can
    // never shadow the peripherals.
    assign dmem_hit = (addr < IO_BASE) && (addr[31:DMEM_AW+2] == '0);
    assign dmem_idx = addr[DMEM_AW+1:2];
    assign io_hit   = (addr[31:4] == IO_BASE[31:4]);
    assign io_off   = addr[3:2];
    // Stores are swallowed while reset is asserted.
    assign wr_en    = reset && bus.mem_mem_write;

    logic led_we;
    logic push_req;
    logic stat_we;
    logic cyc_we;

    assign led_we   = wr_en && io_hit && (io_off == OFF_LED);
    assign push_req = wr_en && io_hit && (io_off == OFF_TX);
    assign stat_we  = wr_en && io_hit && (io_off == OFF_STAT);
    assign cyc_we   = wr_en && io_hit && (io_off == OFF_CYC);

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    logic [31:0] dmem [DMEM_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en && dmem_hit) begin
            dmem[dmem_idx] <= bus.mem_reg_mem;
        end
    end

    // ------------------------------------------------------------------
    // LED register and cycle counter
    // ------------------------------------------------------------------
    logic [15:0] led;
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            led <= 16'h0;
        end else if (led_we) begin
            led <= bus.mem_reg_mem[15:0];
        end
    end

    // A load wins over the increment; counting resumes from the loaded value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt <= 32'h0;
        end else if (cyc_we) begin
            cycle_cnt <= bus.mem_reg_mem;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign bus.led = led;

    // ------------------------------------------------------------------
    // Console TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]        con_buf [CON_DEPTH];
    logic [CON_AW-1:0] rd_ptr;
    logic [CON_AW-1:0] wr_ptr;
    logic [CNT_W-1:0]  con_count;
    logic              con_full;
    logic              con_valid;
    logic              drop;
    logic              pop;
    logic              push_ok;
    logic              drop_evt;

    assign con_full  = (con_count == CNT_W'(CON_DEPTH));
    assign con_valid = (con_count != '0);
    assign pop       = con_valid && bus.con_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push_ok   = push_req && (!con_full || pop);
    assign drop_evt  = push_req && con_full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            con_buf[wr_ptr] <= bus.mem_reg_mem[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            con_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + CON_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CON_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   con_count <= con_count + CNT_W'(1);
                2'b01:   con_count <= con_count - CNT_W'(1);
                default: con_count <= con_count;
            endcase
        end
    end

    // Setting dominates clearing so a drop is never lost.
    always_ff @(posedge clock) begin
        if (!reset) begin
            drop <= 1'b0;
        end else if (drop_evt) begin
            drop <= 1'b1;
        end else if (stat_we) begin
            drop <= 1'b0;
        end
    end

    assign bus.con_valid = con_valid;
    assign bus.con_data  = con_valid ? con_buf[rd_ptr] : 8'h00;

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rd_data;

    assign status_word = {22'b0, drop, con_full, 8'(con_count)};

    always_comb begin
        rd_data = 32'h0;
        if (dmem_hit) begin
            rd_data = dmem[dmem_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_LED:  rd_data = {16'h0, led};
                OFF_TX:   rd_data = 32'h0;
                OFF_STAT: rd_data = status_word;
                OFF_CYC:  rd_data = cycle_cnt;
                default:  rd_data = 32'h0;
            endcase
        end
    end

    assign bus.mem_mem_out = rd_data;

    // Byte-lane bits are ignored: word accesses only.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pc[1:0], addr[1:0]};

endmodule
